// File: rtl/neur_mult_array.sv
// Four-lane mixed-precision signed multiply-and-reduce, two-stage pipeline.
// Stage 1 registers the lane products; stage 2 registers the reduced sum.
module neur_mult_array #(
    parameter bit SAT_EN = 1'b0
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        neur_mult_en,
    input  logic [1:0]  neur_mode,
    input  logic [15:0] mult_oper_a0,
    input  logic [15:0] mult_oper_a1,
    input  logic [15:0] mult_oper_a2,
    input  logic [15:0] mult_oper_a3,
    input  logic [15:0] mult_oper_b0,
    input  logic [15:0] mult_oper_b1,
    input  logic [15:0] mult_oper_b2,
    input  logic [15:0] mult_oper_b3,
    output logic [31:0] mult_prod,
    output logic        mult_valid,
    output logic        busy
);

    // Sub-word products are formed at 32 bits modulo 2^32; every exact
    // lane result fits in signed 32 bits, so the low word is exact.
    function automatic logic [31:0] sx16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] sx8(input logic [7:0] v);
        return {{24{v[7]}}, v};
    endfunction

    function automatic logic [31:0] sx4(input logic [3:0] v);
        return {{28{v[3]}}, v};
    endfunction

    logic [15:0] oper_a [4];
    logic [15:0] oper_b [4];
    logic [31:0] stage1 [4];
    logic        v1_reg;
    logic [31:0] mult_prod_reg;
    logic        mult_valid_reg;

    assign oper_a[0] = mult_oper_a0;
    assign oper_a[1] = mult_oper_a1;
    assign oper_a[2] = mult_oper_a2;
    assign oper_a[3] = mult_oper_a3;
    assign oper_b[0] = mult_oper_b0;
    assign oper_b[1] = mult_oper_b1;
    assign oper_b[2] = mult_oper_b2;
    assign oper_b[3] = mult_oper_b3;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [15:0] a;
            logic [15:0] b;
            logic [31:0] p_full;
            logic [31:0] p_dual;
            logic [31:0] p_quad;
            logic [31:0] lane_next;
            logic [31:0] prod_reg;

            assign a = oper_a[gi];
            assign b = oper_b[gi];

            assign p_full = sx16(a) * sx16(b);
            assign p_dual = sx8(a[15:8]) * sx8(b[15:8])
                          + sx8(a[7:0])  * sx8(b[7:0]);
            assign p_quad = sx4(a[15:12]) * sx4(b[15:12])
                          + sx4(a[11:8])  * sx4(b[11:8])
                          + sx4(a[7:4])   * sx4(b[7:4])
                          + sx4(a[3:0])   * sx4(b[3:0]);

            // Mode 11 is reserved and aliases the full 16x16 product.
            always_comb begin
                case (neur_mode)
                    2'b01:   lane_next = p_dual;
                    2'b10:   lane_next = p_quad;
                    default: lane_next = p_full;
                endcase
            end

            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    prod_reg <= '0;
                end else if (neur_mult_en) begin
                    prod_reg <= lane_next;
                end
            end

            assign stage1[gi] = prod_reg;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            v1_reg <= 1'b0;
        end else begin
            v1_reg <= neur_mult_en;
        end
    end

    logic [33:0] sum_full;
    logic [31:0] sum_next;

    assign sum_full = {{2{stage1[0][31]}}, stage1[0]}
                    + {{2{stage1[1][31]}}, stage1[1]}
                    + {{2{stage1[2][31]}}, stage1[2]}
                    + {{2{stage1[3][31]}}, stage1[3]};

    // Overflow exists iff the top three bits of the 34-bit sum disagree.
    always_comb begin
        sum_next = sum_full[31:0];
        if (SAT_EN && (sum_full[33:31] != 3'b000) && (sum_full[33:31] != 3'b111)) begin
            sum_next = sum_full[33] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mult_prod_reg  <= '0;
            mult_valid_reg <= 1'b0;
        end else begin
            mult_valid_reg <= v1_reg;
            if (v1_reg) begin
                mult_prod_reg <= sum_next;
            end
        end
    end

    assign mult_prod  = mult_prod_reg;
    assign mult_valid = mult_valid_reg;
    assign busy       = v1_reg | mult_valid_reg;

endmodule

// File: tb/tb_neur_mult_array.sv
// Directed checks of neur_mult_array; a wrapping and a saturating instance
// share the same stimulus.
module tb_neur_mult_array;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic [1:0]  mode;
    logic [15:0] a [4];
    logic [15:0] b [4];
    logic [31:0] prod_w, prod_s;
    logic        valid_w, valid_s, busy_w, busy_s;
    int          tests_run = 0;
    int          tests_failed = 0;

    always #5 clk = ~clk;

    neur_mult_array #(.SAT_EN(1'b0)) dut_wrap (
        .clk_i(clk), .rstn_i(rstn), .neur_mult_en(en), .neur_mode(mode),
        .mult_oper_a0(a[0]), .mult_oper_a1(a[1]), .mult_oper_a2(a[2]), .mult_oper_a3(a[3]),
        .mult_oper_b0(b[0]), .mult_oper_b1(b[1]), .mult_oper_b2(b[2]), .mult_oper_b3(b[3]),
        .mult_prod(prod_w), .mult_valid(valid_w), .busy(busy_w)
    );

    neur_mult_array #(.SAT_EN(1'b1)) dut_sat (
        .clk_i(clk), .rstn_i(rstn), .neur_mult_en(en), .neur_mode(mode),
        .mult_oper_a0(a[0]), .mult_oper_a1(a[1]), .mult_oper_a2(a[2]), .mult_oper_a3(a[3]),
        .mult_oper_b0(b[0]), .mult_oper_b1(b[1]), .mult_oper_b2(b[2]), .mult_oper_b3(b[3]),
        .mult_prod(prod_s), .mult_valid(valid_s), .busy(busy_s)
    );

    task automatic set_op(input logic e, input logic [1:0] m,
                          input logic [15:0] a0, input logic [15:0] a1,
                          input logic [15:0] a2, input logic [15:0] a3,
                          input logic [15:0] b0, input logic [15:0] b1,
                          input logic [15:0] b2, input logic [15:0] b3);
        en = e; mode = m;
        a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        if (e) $display("[TB] op mode=%0d a=%h,%h,%h,%h b=%h,%h,%h,%h", m, a0, a1, a2, a3, b0, b1, b2, b3);
    endtask

    // One enabled cycle, then idle; returns at the sample point of its valid.
    task automatic launch(input logic [1:0] m,
                          input logic [15:0] a0, input logic [15:0] a1,
                          input logic [15:0] a2, input logic [15:0] a3,
                          input logic [15:0] b0, input logic [15:0] b1,
                          input logic [15:0] b2, input logic [15:0] b3);
        @(negedge clk);
        set_op(1'b1, m, a0, a1, a2, a3, b0, b1, b2, b3);
        @(negedge clk);
        set_op(1'b0, 2'b00, '0, '0, '0, '0, '0, '0, '0, '0);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        set_op(1'b0, 2'b00, '0, '0, '0, '0, '0, '0, '0, '0);
        repeat (2) @(negedge clk);
        tests_run++; if (prod_w !== 32'h0) begin tests_failed++; $display("FAIL reset_prod_wrap: got %h expected %h", prod_w, 32'h0); end
        tests_run++; if (prod_s !== 32'h0) begin tests_failed++; $display("FAIL reset_prod_sat: got %h expected %h", prod_s, 32'h0); end
        tests_run++; if (valid_w !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", valid_w); end
        tests_run++; if (busy_w !== 1'b0 || busy_s !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b%b expected 00", busy_w, busy_s); end
        rstn = 1'b1;
    endtask

    task automatic test_mode00();
        @(negedge clk);
        set_op(1'b1, 2'b00, 16'd3, '0, '0, '0, 16'hFFFE, '0, '0, '0);
        @(negedge clk);
        set_op(1'b0, 2'b00, '0, '0, '0, '0, '0, '0, '0, '0);
        tests_run++; if (valid_w !== 1'b0 || busy_w !== 1'b1) begin tests_failed++; $display("FAIL m00_latency1: got valid=%b busy=%b expected valid=0 busy=1", valid_w, busy_w); end
        @(negedge clk);
        tests_run++; if (valid_w !== 1'b1 || valid_s !== 1'b1) begin tests_failed++; $display("FAIL m00_valid: got %b%b expected 11", valid_w, valid_s); end
        tests_run++; if (prod_w !== 32'hFFFF_FFFA) begin tests_failed++; $display("FAIL m00_prod_wrap: got %h expected %h", prod_w, 32'hFFFF_FFFA); end
        tests_run++; if (prod_s !== 32'hFFFF_FFFA) begin tests_failed++; $display("FAIL m00_prod_sat: got %h expected %h", prod_s, 32'hFFFF_FFFA); end
        @(negedge clk);
        tests_run++; if (valid_w !== 1'b0 || busy_w !== 1'b0) begin tests_failed++; $display("FAIL m00_single_pulse: got valid=%b busy=%b expected 0 0", valid_w, busy_w); end
        tests_run++; if (prod_w !== 32'hFFFF_FFFA) begin tests_failed++; $display("FAIL m00_prod_hold: got %h expected %h", prod_w, 32'hFFFF_FFFA); end
    endtask

    task automatic test_mode01();
        launch(2'b01, 16'h7F81, 16'h7F81, 16'h7F81, 16'h7F81, 16'h0202, 16'h0202, 16'h0202, 16'h0202);
        tests_run++; if (valid_w !== 1'b1 || prod_w !== 32'd0) begin tests_failed++; $display("FAIL m01_zero: got valid=%b prod=%h expected 1 %h", valid_w, prod_w, 32'd0); end
        launch(2'b01, 16'h7F81, 16'h7F81, 16'h7F81, 16'h7F81, 16'h02FE, 16'h02FE, 16'h02FE, 16'h02FE);
        tests_run++; if (valid_w !== 1'b1 || prod_w !== 32'd2032) begin tests_failed++; $display("FAIL m01_2032: got valid=%b prod=%h expected 1 %h", valid_w, prod_w, 32'd2032); end
    endtask

    task automatic test_mode10();
        launch(2'b10, 16'h8888, '0, '0, '0, 16'h8888, '0, '0, '0);
        tests_run++; if (valid_w !== 1'b1 || prod_w !== 32'd256) begin tests_failed++; $display("FAIL m10_256: got valid=%b prod=%h expected 1 %h", valid_w, prod_w, 32'd256); end
        launch(2'b10, 16'h7777, '0, '0, '0, 16'h8888, '0, '0, '0);
        tests_run++; if (valid_w !== 1'b1 || prod_w !== 32'hFFFF_FF20) begin tests_failed++; $display("FAIL m10_neg224: got valid=%b prod=%h expected 1 %h", valid_w, prod_w, 32'hFFFF_FF20); end
    endtask

    task automatic test_overflow();
        launch(2'b00, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
        tests_run++; if (prod_w !== 32'h0000_0000) begin tests_failed++; $display("FAIL ovf_pos_wrap: got %h expected %h", prod_w, 32'h0); end
        tests_run++; if (prod_s !== 32'h7FFF_FFFF) begin tests_failed++; $display("FAIL ovf_pos_sat: got %h expected %h", prod_s, 32'h7FFF_FFFF); end
        launch(2'b00, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        tests_run++; if (prod_w !== 32'h0002_0000) begin tests_failed++; $display("FAIL ovf_neg_wrap: got %h expected %h", prod_w, 32'h0002_0000); end
        tests_run++; if (prod_s !== 32'h8000_0000) begin tests_failed++; $display("FAIL ovf_neg_sat: got %h expected %h", prod_s, 32'h8000_0000); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        set_op(1'b1, 2'b00, 16'd100, 16'hFFFB, '0, '0, 16'd200, 16'd7, '0, '0);
        @(negedge clk);
        tests_run++; if (valid_w !== 1'b0 || busy_w !== 1'b1) begin tests_failed++; $display("FAIL b2b_first: got valid=%b busy=%b expected 0 1", valid_w, busy_w); end
        set_op(1'b1, 2'b01, 16'h0302, 16'hFF01, '0, '0, 16'h0405, 16'h0A0B, '0, '0);
        @(negedge clk);
        tests_run++; if (valid_w !== 1'b1 || busy_w !== 1'b1 || prod_w !== 32'd19965) begin tests_failed++; $display("FAIL b2b_op0: got valid=%b busy=%b prod=%h expected 1 1 %h", valid_w, busy_w, prod_w, 32'd19965); end
        set_op(1'b1, 2'b10, 16'h1234, '0, 16'hF0F0, '0, 16'h1111, '0, 16'h2222, '0);
        @(negedge clk);
        tests_run++; if (valid_w !== 1'b1 || busy_w !== 1'b1 || prod_w !== 32'd23) begin tests_failed++; $display("FAIL b2b_op1: got valid=%b busy=%b prod=%h expected 1 1 %h", valid_w, busy_w, prod_w, 32'd23); end
        set_op(1'b1, 2'b11, 16'd2, '0, '0, 16'h0100, 16'd3, '0, '0, 16'hFFFF);
        @(negedge clk);
        tests_run++; if (valid_w !== 1'b1 || busy_w !== 1'b1 || prod_w !== 32'd6) begin tests_failed++; $display("FAIL b2b_op2: got valid=%b busy=%b prod=%h expected 1 1 %h", valid_w, busy_w, prod_w, 32'd6); end
        set_op(1'b0, 2'b00, '0, '0, '0, '0, '0, '0, '0, '0);
        @(negedge clk);
        tests_run++; if (valid_w !== 1'b1 || busy_w !== 1'b1 || prod_w !== 32'hFFFF_FF06) begin tests_failed++; $display("FAIL b2b_op3: got valid=%b busy=%b prod=%h expected 1 1 %h", valid_w, busy_w, prod_w, 32'hFFFF_FF06); end
        @(negedge clk);
        tests_run++; if (valid_w !== 1'b0 || busy_w !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain: got valid=%b busy=%b expected 0 0", valid_w, busy_w); end
    endtask

    task automatic test_gap();
        @(negedge clk);
        set_op(1'b1, 2'b00, 16'd1, '0, '0, '0, 16'd1, '0, '0, '0);
        @(negedge clk);
        set_op(1'b0, 2'b01, 16'hDEAD, 16'hBEEF, 16'h1234, 16'h5678, 16'hCAFE, 16'hF00D, 16'h9ABC, 16'hDEF0);
        @(negedge clk);
        tests_run++; if (valid_w !== 1'b1 || prod_w !== 32'd1) begin tests_failed++; $display("FAIL gap_op0: got valid=%b prod=%h expected 1 %h", valid_w, prod_w, 32'd1); end
        set_op(1'b1, 2'b00, 16'd2, '0, '0, '0, 16'd2, '0, '0, '0);
        @(negedge clk);
        set_op(1'b0, 2'b10, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h7777, 16'h7777, 16'h7777, 16'h7777);
        tests_run++; if (valid_w !== 1'b0 || busy_w !== 1'b1 || prod_w !== 32'd1) begin tests_failed++; $display("FAIL gap_hole: got valid=%b busy=%b prod=%h expected 0 1 %h", valid_w, busy_w, prod_w, 32'd1); end
        @(negedge clk);
        tests_run++; if (valid_w !== 1'b1 || prod_w !== 32'd4) begin tests_failed++; $display("FAIL gap_op1: got valid=%b prod=%h expected 1 %h", valid_w, prod_w, 32'd4); end
        set_op(1'b0, 2'b00, '0, '0, '0, '0, '0, '0, '0, '0);
        @(negedge clk);
        tests_run++; if (valid_w !== 1'b0 || busy_w !== 1'b0) begin tests_failed++; $display("FAIL gap_drain: got valid=%b busy=%b expected 0 0", valid_w, busy_w); end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        set_op(1'b1, 2'b00, 16'd5, '0, '0, '0, 16'd5, '0, '0, '0);
        @(negedge clk);
        set_op(1'b1, 2'b00, 16'd6, '0, '0, '0, 16'd6, '0, '0, '0);
        rstn = 1'b0;
        #1;
        tests_run++; if (busy_w !== 1'b0 || valid_w !== 1'b0 || prod_w !== 32'd0) begin tests_failed++; $display("FAIL rst_async: got busy=%b valid=%b prod=%h expected 0 0 0", busy_w, valid_w, prod_w); end
        @(negedge clk);
        rstn = 1'b1;
        set_op(1'b0, 2'b00, '0, '0, '0, '0, '0, '0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++; if (valid_w !== 1'b0 || busy_w !== 1'b0 || prod_w !== 32'd0) begin tests_failed++; $display("FAIL rst_discard%0d: got valid=%b busy=%b prod=%h expected 0 0 0", i, valid_w, busy_w, prod_w); end
        end
    endtask

    task automatic test_enable_after_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        set_op(1'b1, 2'b00, 16'd7, '0, '0, '0, 16'd9, '0, '0, '0);
        @(negedge clk);
        set_op(1'b0, 2'b00, '0, '0, '0, '0, '0, '0, '0, '0);
        tests_run++; if (valid_w !== 1'b0 || busy_w !== 1'b1) begin tests_failed++; $display("FAIL post_rst_accept: got valid=%b busy=%b expected 0 1", valid_w, busy_w); end
        @(negedge clk);
        tests_run++; if (valid_w !== 1'b1 || prod_w !== 32'd63) begin tests_failed++; $display("FAIL post_rst_result: got valid=%b prod=%h expected 1 %h", valid_w, prod_w, 32'd63); end
        @(negedge clk);
        tests_run++; if (valid_w !== 1'b0 || busy_w !== 1'b0) begin tests_failed++; $display("FAIL post_rst_drain: got valid=%b busy=%b expected 0 0", valid_w, busy_w); end
    endtask

    initial begin
        test_reset();
        test_mode00();
        test_mode01();
        test_mode10();
        test_overflow();
        test_back_to_back();
        test_gap();
        test_reset_midflight();
        test_enable_after_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
